spw_link_ctrl: RTL and testbench

SPW_LINK_CTRL -- requirements
Module: spw_link_ctrl

---
 rtl/spw_link_pkg.sv | 27 ++
 rtl/spw_fct_credit.sv | 59 +++++
 rtl/spw_link_ctrl.sv | 135 +++++++++++++
 tb/tb_spw_link_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spw_link_pkg.sv
// SpaceWire link controller shared types.
// Link state encoding, FCT handshake states and timing defaults.
package spw_link_pkg;

    typedef enum logic [2:0] {
        ST_ERROR_RESET = 3'd0,
        ST_ERROR_WAIT  = 3'd1,
        ST_READY       = 3'd2,
        ST_STARTED     = 3'd3,
        ST_CONNECTING  = 3'd4,
        ST_RUN         = 3'd5
    } link_state_e;

    typedef enum logic [1:0] {
        FCT_IDLE   = 2'd0,
        FCT_REQ    = 2'd1,
        FCT_ACKLOW = 2'd2
    } fct_hs_e;

    localparam int unsigned T_6U4_DEF  = 640;
    localparam int unsigned T_12U8_DEF = 1280;

    // Credit granted per FCT and the highest credit at which another FCT fits.
    localparam logic [6:0] CREDIT_STEP    = 7'd8;
    localparam logic [6:0] CREDIT_REQ_MAX = 7'd48;

endpackage

// File: rtl/spw_fct_credit.sv
// Receive credit counter and 4-phase FCT request handshake.
// Tracks credit granted to the far end; flags N-Chars received without credit.
module spw_fct_credit
    import spw_link_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       active_i,
    input  logic       got_nchar_i,
    input  logic [6:0] fifo_free_i,
    input  logic       ack_i,
    output logic       req_o,
    output logic [6:0] credit_o,
    output logic       credit_err_o
);

    fct_hs_e    hs_q, hs_d;
    logic [6:0] credit_q, credit_d;
    logic       room;
    logic       grant;
    logic       take;

    // Next handshake state and credit; clr_i overrides everything.
    always_comb begin
        room  = (credit_q <= CREDIT_REQ_MAX) &&
                ({1'b0, fifo_free_i} >= ({1'b0, credit_q} + {1'b0, CREDIT_STEP}));
        grant = (hs_q == FCT_REQ) && ack_i;
        take  = got_nchar_i && (credit_q != 7'd0);
        hs_d  = hs_q;
        case (hs_q)
            FCT_IDLE:   if (active_i && room) hs_d = FCT_REQ;
            FCT_REQ:    if (ack_i) hs_d = FCT_ACKLOW;
            FCT_ACKLOW: if (!ack_i) hs_d = FCT_IDLE;
            default:    hs_d = FCT_IDLE;
        endcase
        credit_d = credit_q + (grant ? CREDIT_STEP : 7'd0) - (take ? 7'd1 : 7'd0);
        if (clr_i) begin
            hs_d     = FCT_IDLE;
            credit_d = 7'd0;
        end
    end

    // Handshake and credit registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_q     <= FCT_IDLE;
            credit_q <= 7'd0;
        end else begin
            hs_q     <= hs_d;
            credit_q <= credit_d;
        end
    end

    assign req_o        = (hs_q == FCT_REQ);
    assign credit_o     = credit_q;
    assign credit_err_o = got_nchar_i && (credit_q == 7'd0);

endmodule

// File: rtl/spw_link_ctrl.sv
// SpaceWire link state machine with dwell/timeout timer.
// Outputs are registered from the next state so they match the state register.
module spw_link_ctrl
    import spw_link_pkg::*;
#(
    parameter int unsigned T_6U4  = T_6U4_DEF,
    parameter int unsigned T_12U8 = T_12U8_DEF,
    parameter int unsigned TMR_W  = 16
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       LINK_START,
    input  logic       LINK_DISABLE,
    input  logic       AUTOSTART,
    input  logic       gotNULL,
    input  logic       gotFCT,
    input  logic       gotNChar,
    input  logic       gotTimeCode,
    input  logic       rxError,
    input  logic       creditErr,
    input  logic [6:0] rxFifoFree,
    input  logic       sendFctAck,
    output logic       resetTx,
    output logic       enableTx,
    output logic       enableRx,
    output logic       sendNULLs,
    output logic       sendFCTs,
    output logic       sendNChars,
    output logic       sendTimeCodes,
    output logic       sendFctReq,
    output logic [2:0] LINK_STATE
);

    localparam logic [TMR_W-1:0] T64_LAST  = TMR_W'(T_6U4 - 1);
    localparam logic [TMR_W-1:0] T128_LAST = TMR_W'(T_12U8 - 1);

    link_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             reset_tx_q, en_tx_q, en_rx_q;
    logic             nulls_q, fcts_q, nchars_q, tcodes_q;
    logic             rx_credit_err;
    logic             err, rx_evt, t64, t128, go;
    logic             fct_active, fct_clr;
    logic [6:0]       rx_credit;

    // Link state transitions; the error branch is tested before any advance.
    always_comb begin
        err     = rxError | creditErr | rx_credit_err;
        rx_evt  = gotFCT | gotNChar | gotTimeCode;
        t64     = (timer_q == T64_LAST);
        t128    = (timer_q == T128_LAST);
        go      = !LINK_DISABLE && (LINK_START || (AUTOSTART && gotNULL));
        state_d = state_q;
        case (state_q)
            ST_ERROR_RESET: begin
                if (t64) state_d = ST_ERROR_WAIT;
            end
            ST_ERROR_WAIT: begin
                if (err || rx_evt) state_d = ST_ERROR_RESET;
                else if (t128) state_d = ST_READY;
            end
            ST_READY: begin
                if (err || rx_evt) state_d = ST_ERROR_RESET;
                else if (go) state_d = ST_STARTED;
            end
            ST_STARTED: begin
                if (err || rx_evt || LINK_DISABLE || t128) state_d = ST_ERROR_RESET;
                else if (gotNULL) state_d = ST_CONNECTING;
            end
            ST_CONNECTING: begin
                if (err || gotNChar || gotTimeCode || LINK_DISABLE || t128)
                    state_d = ST_ERROR_RESET;
                else if (gotFCT) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (err || LINK_DISABLE) state_d = ST_ERROR_RESET;
            end
            default: state_d = ST_ERROR_RESET;
        endcase
        if (state_d != state_q) timer_d = '0;
        else if (state_q == ST_RUN) timer_d = timer_q;
        else timer_d = timer_q + 1'b1;
    end

    // State, timer and output registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_ERROR_RESET;
            timer_q    <= '0;
            reset_tx_q <= 1'b0;
            en_tx_q    <= 1'b0;
            en_rx_q    <= 1'b0;
            nulls_q    <= 1'b0;
            fcts_q     <= 1'b0;
            nchars_q   <= 1'b0;
            tcodes_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            reset_tx_q <= (state_d != ST_ERROR_RESET);
            en_rx_q    <= (state_d != ST_ERROR_RESET);
            en_tx_q    <= (state_d inside {ST_STARTED, ST_CONNECTING, ST_RUN});
            nulls_q    <= (state_d inside {ST_STARTED, ST_CONNECTING, ST_RUN});
            fcts_q     <= (state_d inside {ST_CONNECTING, ST_RUN});
            nchars_q   <= (state_d == ST_RUN);
            tcodes_q   <= (state_d == ST_RUN);
        end
    end

    assign fct_active = (state_q == ST_CONNECTING) || (state_q == ST_RUN);
    assign fct_clr    = (state_d == ST_ERROR_RESET);

    spw_fct_credit u_fct (
        .clk_i        (CLOCK),
        .rst_i        (RESET),
        .clr_i        (fct_clr),
        .active_i     (fct_active),
        .got_nchar_i  (gotNChar),
        .fifo_free_i  (rxFifoFree),
        .ack_i        (sendFctAck),
        .req_o        (sendFctReq),
        .credit_o     (rx_credit),
        .credit_err_o (rx_credit_err)
    );

    assign resetTx       = reset_tx_q;
    assign enableTx      = en_tx_q;
    assign enableRx      = en_rx_q;
    assign sendNULLs     = nulls_q;
    assign sendFCTs      = fcts_q;
    assign sendNChars    = nchars_q;
    assign sendTimeCodes = tcodes_q;
    assign LINK_STATE    = state_q;

endmodule

// File: tb/tb_spw_link_ctrl.sv
// Directed bench for spw_link_ctrl with short timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spw_link_ctrl;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       LINK_START, LINK_DISABLE, AUTOSTART;
    logic       gotNULL, gotFCT, gotNChar, gotTimeCode;
    logic       rxError, creditErr;
    logic [6:0] rxFifoFree;
    logic       sendFctAck;
    logic       resetTx, enableTx, enableRx, sendNULLs, sendFCTs;
    logic       sendNChars, sendTimeCodes, sendFctReq;
    logic [2:0] LINK_STATE;

    int ncmp  = 0;
    int nfail = 0;

    always #5 CLOCK = ~CLOCK;

    spw_link_ctrl #(
        .T_6U4  (8),
        .T_12U8 (16),
        .TMR_W  (16)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .LINK_START    (LINK_START),
        .LINK_DISABLE  (LINK_DISABLE),
        .AUTOSTART     (AUTOSTART),
        .gotNULL       (gotNULL),
        .gotFCT        (gotFCT),
        .gotNChar      (gotNChar),
        .gotTimeCode   (gotTimeCode),
        .rxError       (rxError),
        .creditErr     (creditErr),
        .rxFifoFree    (rxFifoFree),
        .sendFctAck    (sendFctAck),
        .resetTx       (resetTx),
        .enableTx      (enableTx),
        .enableRx      (enableRx),
        .sendNULLs     (sendNULLs),
        .sendFCTs      (sendFCTs),
        .sendNChars    (sendNChars),
        .sendTimeCodes (sendTimeCodes),
        .sendFctReq    (sendFctReq),
        .LINK_STATE    (LINK_STATE)
    );

    logic [6:0] credit;
    assign credit = dut.u_fct.credit_q;

    task automatic tick();
        @(negedge CLOCK);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] exp, input int budget);
        int n = 0;
        while (LINK_STATE !== exp && n < budget) begin
            tick();
            n++;
        end
        chk("wait_state", {5'd0, LINK_STATE}, {5'd0, exp});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; LINK_START = 1'b0; LINK_DISABLE = 1'b0; AUTOSTART = 1'b0;
        gotNULL = 1'b0; gotFCT = 1'b0; gotNChar = 1'b0; gotTimeCode = 1'b0;
        rxError = 1'b0; creditErr = 1'b0; rxFifoFree = 7'd0; sendFctAck = 1'b0;

        // Reset values appear without a clock edge
        #2 RESET = 1'b1;
        #1;
        chk("rst_state", {5'd0, LINK_STATE}, 8'd0);
        chk("rst_resetTx", {7'd0, resetTx}, 8'd0);
        chk("rst_enableRx", {7'd0, enableRx}, 8'd0);
        chk("rst_enableTx", {7'd0, enableTx}, 8'd0);
        chk("rst_sendNULLs", {7'd0, sendNULLs}, 8'd0);
        chk("rst_fctreq", {7'd0, sendFctReq}, 8'd0);
        tick(); tick();

        // ErrorReset 8 clocks, ErrorWait 16 clocks, then Ready and Started
        LINK_START = 1'b1;
        RESET = 1'b0;
        chk("er_dwell", {5'd0, LINK_STATE}, 8'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("er_dwell", {5'd0, LINK_STATE}, 8'd0);
        end
        tick();
        chk("ew_enter", {5'd0, LINK_STATE}, 8'd1);
        chk("ew_resetTx", {7'd0, resetTx}, 8'd1);
        chk("ew_enableRx", {7'd0, enableRx}, 8'd1);
        chk("ew_enableTx", {7'd0, enableTx}, 8'd0);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("ew_dwell", {5'd0, LINK_STATE}, 8'd1);
        end
        tick();
        chk("ready", {5'd0, LINK_STATE}, 8'd2);
        tick();
        chk("started", {5'd0, LINK_STATE}, 8'd3);
        chk("st_enableTx", {7'd0, enableTx}, 8'd1);
        chk("st_sendNULLs", {7'd0, sendNULLs}, 8'd1);
        chk("st_sendFCTs", {7'd0, sendFCTs}, 8'd0);
        tick(); tick();
        gotNULL = 1'b1;
        tick();
        chk("connecting", {5'd0, LINK_STATE}, 8'd4);
        chk("cn_sendFCTs", {7'd0, sendFCTs}, 8'd1);
        chk("cn_sendNChars", {7'd0, sendNChars}, 8'd0);
        chk("cn_fctreq_empty", {7'd0, sendFctReq}, 8'd0);

        // FIFO room boundary, then a slow acknowledge
        rxFifoFree = 7'd7;
        tick();
        chk("fifo7_noreq", {7'd0, sendFctReq}, 8'd0);
        rxFifoFree = 7'd64;
        tick();
        chk("fifo64_req", {7'd0, sendFctReq}, 8'd1);
        tick(); tick();
        chk("req_held", {7'd0, sendFctReq}, 8'd1);
        chk("credit_pre_ack", {1'b0, credit}, 8'd0);
        sendFctAck = 1'b1;
        tick();
        chk("credit_ack", {1'b0, credit}, 8'd8);
        chk("req_acklow", {7'd0, sendFctReq}, 8'd0);
        sendFctAck = 1'b0;
        gotFCT = 1'b1;
        tick();
        gotFCT = 1'b0;
        chk("run", {5'd0, LINK_STATE}, 8'd5);
        chk("run_sendNChars", {7'd0, sendNChars}, 8'd1);
        chk("run_sendTimeCodes", {7'd0, sendTimeCodes}, 8'd1);
        tick();
        chk("run_req", {7'd0, sendFctReq}, 8'd1);

        // Five more grants bring credit to 48
        for (int i = 0; i < 5; i++) begin
            sendFctAck = 1'b1;
            tick();
            sendFctAck = 1'b0;
            tick();
            tick();
        end
        chk("credit_48", {1'b0, credit}, 8'd48);
        chk("req_at_48", {7'd0, sendFctReq}, 8'd1);
        sendFctAck = 1'b1;
        gotNChar = 1'b1;
        tick();
        sendFctAck = 1'b0;
        gotNChar = 1'b0;
        chk("credit_net7", {1'b0, credit}, 8'd55);
        tick(); tick();
        chk("noreq_55", {7'd0, sendFctReq}, 8'd0);
        tick();
        chk("noreq_55b", {7'd0, sendFctReq}, 8'd0);
        chk("run_hold", {5'd0, LINK_STATE}, 8'd5);

        // Drain all credit, then one N-Char too many
        gotNChar = 1'b1;
        repeat (55) tick();
        chk("credit_drained", {1'b0, credit}, 8'd0);
        chk("run_drained", {5'd0, LINK_STATE}, 8'd5);
        chk("req_drained", {7'd0, sendFctReq}, 8'd1);
        tick();
        gotNChar = 1'b0;
        chk("overrun_state", {5'd0, LINK_STATE}, 8'd0);
        chk("overrun_credit", {1'b0, credit}, 8'd0);
        chk("overrun_req", {7'd0, sendFctReq}, 8'd0);
        chk("overrun_resetTx", {7'd0, resetTx}, 8'd0);
        chk("overrun_nchars", {7'd0, sendNChars}, 8'd0);

        // LINK_DISABLE holds Ready; Started times out without NULLs
        gotNULL = 1'b0;
        LINK_DISABLE = 1'b1;
        wait_state(3'd2, 40);
        tick(); tick();
        chk("ready_disabled", {5'd0, LINK_STATE}, 8'd2);
        LINK_DISABLE = 1'b0;
        tick();
        chk("started2", {5'd0, LINK_STATE}, 8'd3);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("st_dwell", {5'd0, LINK_STATE}, 8'd3);
        end
        tick();
        chk("st_timeout", {5'd0, LINK_STATE}, 8'd0);
        chk("st_timeout_resetTx", {7'd0, resetTx}, 8'd0);
        chk("st_timeout_enableTx", {7'd0, enableTx}, 8'd0);

        // Autostart path, exact FIFO room, then reset mid-request
        LINK_START = 1'b0;
        AUTOSTART = 1'b1;
        gotNULL = 1'b1;
        rxFifoFree = 7'd8;
        wait_state(3'd4, 40);
        tick();
        chk("fifo8_req", {7'd0, sendFctReq}, 8'd1);
        #2 RESET = 1'b1;
        #1;
        chk("async_fctreq", {7'd0, sendFctReq}, 8'd0);
        chk("async_resetTx", {7'd0, resetTx}, 8'd0);
        chk("async_state", {5'd0, LINK_STATE}, 8'd0);
        chk("async_enableRx", {7'd0, enableRx}, 8'd0);
        tick();
        RESET = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
